// File: rtl/photon_subcells_ctrl.sv
// PHOTON SubCells controller: applies the 4-bit PHOTON S-box to all 25 cells
// of a 5x5 state, LANES cells per cycle, over NGRP = 25/LANES RUN cycles.

// Single PHOTON 4-bit S-box lane.
module photon_sbox (
  input  logic [3:0] x,
  output logic [3:0] y
);
  // Combinational S-box lookup.
  always_comb begin
    y = 4'h0;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
  end
endmodule

module photon_subcells_ctrl #(
  parameter int LANES = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [99:0]  state_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [99:0]  state_out
);
  localparam int NCELL = 25;
  localparam int NGRP  = NCELL / LANES;
  localparam int GW    = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

  st_t st, st_nxt;
  logic [GW-1:0]               grp;
  logic [NCELL-1:0][3:0]       work, work_nxt;
  logic [LANES-1:0][3:0]       sin, sout;
  logic [LANES-1:0][4:0]       cidx;
  logic                        last;

  assign last = (grp == GW'(NGRP - 1));

  // Cell index served by each lane in the current group.
  always_comb begin
    cidx = '0;
    for (int l = 0; l < LANES; l++)
      cidx[l] = 5'(int'(grp) * LANES + l);
  end

  // Gather the group's cells into the lanes.
  always_comb begin
    sin = '0;
    for (int l = 0; l < LANES; l++)
      sin[l] = work[cidx[l]];
  end

  genvar gl;
  generate
    for (gl = 0; gl < LANES; gl++) begin : g_lane
      photon_sbox u_sbox (.x(sin[gl]), .y(sout[gl]));
    end
  endgenerate

  // Scatter substituted cells back into the working state.
  always_comb begin
    work_nxt = work;
    for (int l = 0; l < LANES; l++)
      work_nxt[cidx[l]] = sout[l];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  // Next-state and status outputs; status is a one-hot view of the state.
  always_comb begin
    st_nxt = st;
    ready  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (st)
      IDLE: begin
        ready = 1'b1;
        if (start) st_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) st_nxt = DONE;
      end
      DONE: begin
        done   = 1'b1;
        st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Datapath: capture, per-group substitution, publish only the final result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work      <= '0;
      grp       <= '0;
      state_out <= '0;
    end else begin
      case (st)
        IDLE: if (start) begin
          work <= state_in;
          grp  <= '0;
        end
        RUN: begin
          work <= work_nxt;
          grp  <= grp + 1'b1;
          if (last) state_out <= work_nxt;
        end
        default: grp <= '0;
      endcase
    end
  end
endmodule
